// File: rtl/yacht_turn_controller.sv
// yacht_turn_controller: turn/roll sequencer gating dice rolls, score handshake, player and round tracking
module yacht_turn_controller #(
  parameter int ROLL_CYCLES = 8,
  parameter int MAX_ROLLS   = 3,
  parameter int NUM_ROUNDS  = 12,
  parameter int NUM_PLAYERS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       roll_btn,
  input  logic       score_btn,
  input  logic [4:0] hold_sw,
  input  logic       score_ack,
  output logic       roll_en,
  output logic [4:0] hold_mask,
  output logic       score_req,
  output logic [1:0] roll_count,
  output logic       player,
  output logic [3:0] round_num,
  output logic       dice_valid,
  output logic       game_over
);
  typedef enum logic [2:0] {IDLE, READY, ROLLING, DECIDE, SCORE_WAIT, NEXT_TURN, GAME_OVER} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        last;
  logic        last_player, end_game, can_roll;
  assign last_player = player == 1'(NUM_PLAYERS - 1);
  assign end_game    = last_player && round_num == 4'(NUM_ROUNDS);
  assign can_roll    = roll_count < 2'(MAX_ROLLS) && hold_sw != 5'b11111;
  // Turn sequencer; every output is a register updated on the transition that defines it
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b0;
      roll_en    <= 1'b0;
      hold_mask  <= '0;
      score_req  <= 1'b0;
      roll_count <= '0;
      player     <= 1'b0;
      round_num  <= 4'd1;
      dice_valid <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      case (state)
        IDLE, GAME_OVER: if (start_btn) begin
          state      <= READY;
          player     <= 1'b0;
          round_num  <= 4'd1;
          roll_count <= '0;
          hold_mask  <= '0;
          dice_valid <= 1'b0;
          game_over  <= 1'b0;
        end
        READY: if (roll_btn) begin
          state     <= ROLLING;
          hold_mask <= '0;
          roll_en   <= 1'b1;
          cnt       <= 16'(ROLL_CYCLES - 1);
        end
        ROLLING: if (cnt == 16'd0) begin
          state      <= DECIDE;
          roll_en    <= 1'b0;
          roll_count <= roll_count + 2'd1;
          dice_valid <= 1'b1;
        end else cnt <= cnt - 16'd1;
        DECIDE: if (score_btn) begin
          state     <= SCORE_WAIT;
          score_req <= 1'b1;
        end else if (roll_btn && can_roll) begin
          state      <= ROLLING;
          hold_mask  <= hold_sw;
          roll_en    <= 1'b1;
          dice_valid <= 1'b0;
          cnt        <= 16'(ROLL_CYCLES - 1);
        end
        SCORE_WAIT: if (score_ack) begin
          state      <= NEXT_TURN;
          score_req  <= 1'b0;
          roll_count <= '0;
          hold_mask  <= '0;
          dice_valid <= 1'b0;
          last       <= end_game;
          player     <= last_player ? 1'b0 : player + 1'b1;
          round_num  <= (last_player && !end_game) ? round_num + 4'd1 : round_num;
        end
        NEXT_TURN: begin
          state     <= last ? GAME_OVER : READY;
          game_over <= last;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_yacht_turn_controller.sv
// tb_yacht_turn_controller: directed self-checking bench for yacht_turn_controller
module tb_yacht_turn_controller;
  logic       clk = 0, reset = 1, start_btn = 0, roll_btn = 0, score_btn = 0, score_ack = 0;
  logic [4:0] hold_sw = 0;
  logic       roll_en, score_req, player, dice_valid, game_over;
  logic [4:0] hold_mask;
  logic [1:0] roll_count;
  logic [3:0] round_num;
  int n_assert = 0, n_fail = 0, n, bad;

  yacht_turn_controller #(.ROLL_CYCLES(8), .MAX_ROLLS(3), .NUM_ROUNDS(2), .NUM_PLAYERS(2)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .roll_btn(roll_btn), .score_btn(score_btn),
    .hold_sw(hold_sw), .score_ack(score_ack), .roll_en(roll_en), .hold_mask(hold_mask),
    .score_req(score_req), .roll_count(roll_count), .player(player), .round_num(round_num),
    .dice_valid(dice_valid), .game_over(game_over));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start_btn = 1; tick(); start_btn = 0;
  endtask

  task automatic pulse_score();
    score_btn = 1; tick(); score_btn = 0;
  endtask

  task automatic pulse_ack();
    score_ack = 1; tick(); score_ack = 0;
  endtask

  task automatic do_roll(input logic tog, output int cnt, output int nbad);
    logic [4:0] m;
    roll_btn = 1; tick(); roll_btn = 0;
    cnt = 0; nbad = 0; m = hold_mask;
    while (roll_en === 1'b1 && cnt < 50) begin
      cnt++;
      if (hold_mask !== m) nbad++;
      if (tog) hold_sw = hold_sw ^ 5'b11100;
      tick();
    end
  endtask

  task automatic play_turn();
    do_roll(0, n, bad);
    pulse_score();
    repeat (2) tick();
    pulse_ack();
    tick();
  endtask

  initial begin
    reset = 1;
    repeat (3) tick();
    chk("rst_roll_en", roll_en, 0);
    chk("rst_hold_mask", hold_mask, 0);
    chk("rst_score_req", score_req, 0);
    chk("rst_roll_count", roll_count, 0);
    chk("rst_player", player, 0);
    chk("rst_round", round_num, 1);
    chk("rst_dice_valid", dice_valid, 0);
    chk("rst_game_over", game_over, 0);
    reset = 0;
    tick();
    pulse_start();
    chk("start_roll_count", roll_count, 0);
    chk("start_round", round_num, 1);
    chk("start_player", player, 0);
    pulse_score();
    chk("ready_score_ignored", score_req, 0);

    hold_sw = 5'b10101;
    do_roll(0, n, bad);
    chk("r1_len", n, 8);
    chk("r1_mask", hold_mask, 0);
    chk("r1_count", roll_count, 1);
    chk("r1_valid", dice_valid, 1);
    pulse_ack();
    chk("ack_outside_player", player, 0);
    chk("ack_outside_count", roll_count, 1);

    hold_sw = 5'b00011;
    do_roll(1, n, bad);
    chk("r2_len", n, 8);
    chk("r2_mask_stable", bad, 0);
    chk("r2_mask", hold_mask, 5'b00011);
    chk("r2_count", roll_count, 2);

    hold_sw = 5'b00001;
    do_roll(0, n, bad);
    chk("r3_len", n, 8);
    chk("r3_mask", hold_mask, 5'b00001);
    chk("r3_count", roll_count, 3);
    do_roll(0, n, bad);
    repeat (2) tick();
    chk("r4_no_roll", n, 0);
    chk("r4_roll_en", roll_en, 0);
    chk("r4_count", roll_count, 3);

    roll_btn = 1; score_btn = 1; tick(); roll_btn = 0; score_btn = 0;
    chk("both_score_req", score_req, 1);
    chk("both_roll_en", roll_en, 0);
    chk("both_valid", dice_valid, 1);
    repeat (4) tick();
    chk("wait_score_req", score_req, 1);
    pulse_ack();
    chk("ack_score_req", score_req, 0);
    chk("ack_player", player, 1);
    chk("ack_count", roll_count, 0);
    chk("ack_valid", dice_valid, 0);
    tick();

    hold_sw = 5'b11111;
    do_roll(0, n, bad);
    chk("p1_first_len", n, 8);
    chk("p1_first_mask", hold_mask, 0);
    do_roll(0, n, bad);
    chk("allheld_no_roll", n, 0);
    chk("allheld_count", roll_count, 1);
    pulse_score();
    tick();
    pulse_ack();
    chk("t2_player", player, 0);
    chk("t2_round", round_num, 2);
    tick();

    hold_sw = 5'b00000;
    play_turn();
    chk("t3_player", player, 1);
    chk("t3_round", round_num, 2);
    chk("t3_game_over", game_over, 0);
    do_roll(0, n, bad);
    pulse_score();
    pulse_ack();
    chk("t4_player", player, 0);
    chk("t4_round_held", round_num, 2);
    tick();
    chk("t4_game_over", game_over, 1);
    chk("t4_round", round_num, 2);
    pulse_start();
    chk("restart_game_over", game_over, 0);
    chk("restart_round", round_num, 1);
    chk("restart_player", player, 0);

    roll_btn = 1; tick(); roll_btn = 0;
    repeat (3) tick();
    chk("mid_roll_en", roll_en, 1);
    reset = 1; tick(); reset = 0;
    chk("rstroll_roll_en", roll_en, 0);
    chk("rstroll_count", roll_count, 0);
    roll_btn = 1; tick(); roll_btn = 0;
    chk("idle_roll_ignored", roll_en, 0);

    pulse_start();
    do_roll(0, n, bad);
    pulse_score();
    chk("sw_score_req", score_req, 1);
    tick();
    reset = 1; tick(); reset = 0;
    chk("rstsw_score_req", score_req, 0);
    chk("rstsw_valid", dice_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/yacht_turn_controller.md
# yacht_turn_controller

Turn/roll sequencer for the Yacht Dice game. Sits between the debounced front-panel buttons and `Dice_Manager`, which it drives through `roll_en` and a hold mask. It also gates rolls per turn (max three), handles the request/ack handshake with the scoring block, and tracks player, round and game-over.

## Interface
- `ROLL_CYCLES`, default 8: length of the roll animation in cycles (`roll_en` held high); legal range 1..2^16-1.
- `MAX_ROLLS`, default 3: rolls allowed per turn; legal range 1..3.
- `NUM_ROUNDS`, default 12: rounds per game; legal range 1..15.
- `NUM_PLAYERS`, default 2: players alternating turns; legal range 1..2.

Ports:
- `clk` input 1: system clock, single domain.
- `reset` input 1: synchronous, active-high reset.
- `start_btn` input 1: one-cycle pulse; starts a game from IDLE or GAME_OVER.
- `roll_btn` input 1: one-cycle pulse; requests a roll.
- `score_btn` input 1: one-cycle pulse; ends the roll phase and commits a score.
- `hold_sw` input 5: DIP hold switches; bit i=1 holds die i+1.
- `score_ack` input 1: scoring block done; one-cycle pulse.
- `roll_en` output 1: to `Dice_Manager`; high for exactly ROLL_CYCLES consecutive cycles per roll.
- `hold_mask` output 5: to `Dice_Manager` `hold_sw`; frozen while rolling.
- `score_req` output 1: level; high from score request until `score_ack`.
- `roll_count` output 2: rolls taken this turn (0..MAX_ROLLS).
- `player` output 1: current player (0/1).
- `round_num` output 4: current round, 1-based.
- `dice_valid` output 1: dice stable and at least one roll taken this turn.
- `game_over` output 1: level; high in GAME_OVER.

## Operation
- States: IDLE, READY, ROLLING, DECIDE, SCORE_WAIT, NEXT_TURN, GAME_OVER. All outputs are registered.
- Reset values: state=IDLE. `roll_en`=0, `hold_mask`=0, `score_req`=0, `roll_count`=0, `player`=0, `round_num`=1, `dice_valid`=0, `game_over`=0. Reset wins over every other input, including mid-ROLLING and mid-SCORE_WAIT.
- IDLE: `start_btn` -> READY, with `player`=0, `round_num`=1, `roll_count`=0.
- READY (no roll yet this turn):
  - `roll_btn` -> ROLLING with `hold_mask` forced to 00000; the first roll always rolls all dice.
  - `score_btn` is ignored.
- ROLLING:
  - `roll_en`=1 and a down-counter runs for ROLL_CYCLES cycles.
  - On the last cycle: `roll_count`+1, then -> DECIDE.
  - All buttons are ignored.
- DECIDE:
  - `dice_valid`=1.
  - `score_btn` -> SCORE_WAIT.
  - `roll_btn` with `roll_count`<MAX_ROLLS and `hold_sw`!=11111 -> ROLLING; `hold_mask` latches `hold_sw` on that edge.
  - `roll_btn` with `roll_count`==MAX_ROLLS or `hold_sw`==11111 is ignored; no roll is consumed.
  - `roll_btn` and `score_btn` in the same cycle: score wins.
- SCORE_WAIT:
  - `score_req`=1 and `dice_valid`=1.
  - `score_ack` -> NEXT_TURN.
  - `score_ack` outside SCORE_WAIT is ignored.
- NEXT_TURN (one cycle):
  - `roll_count`=0, `hold_mask`=0, `dice_valid`=0.
  - If `player`==NUM_PLAYERS-1: `player`=0 and `round_num`+1; else `player`+1.
  - If the round just finished was NUM_ROUNDS -> GAME_OVER, with `round_num` held at NUM_ROUNDS; else -> READY.
- GAME_OVER: `game_over`=1. `start_btn` -> READY with the IDLE-start initialization.
- `start_btn` outside IDLE and GAME_OVER is ignored.
- `hold_sw` changes outside the latch edge have no effect on `hold_mask`.

## Timing
- Roll latency: `roll_btn` sampled at edge t -> `roll_en`=1 in cycles t+1..t+ROLL_CYCLES, and 0 at t+ROLL_CYCLES+1.
- `roll_count` increments and `dice_valid` rises at t+ROLL_CYCLES+1.
- The next `roll_btn` is accepted no earlier than edge t+ROLL_CYCLES+1.
- Score handshake:
  - `score_btn` at t -> `score_req`=1 from t+1.
  - `score_ack` at u -> `score_req`=0 at u+1, NEXT_TURN at u+1, READY (or GAME_OVER) at u+2.
  - `score_ack` in the same cycle `score_req` first rises is not possible; ack is only sampled in SCORE_WAIT.
- `hold_mask` is stable for the full `roll_en` window and one cycle beyond.

## Test plan
- Reset and start: hold `reset`=1 for 3 cycles, then `start_btn` -> all outputs at their reset values during reset; then READY with `roll_count`=0, `round_num`=1, `player`=0.
- First-roll override: `hold_sw`=10101 and `roll_btn` in READY -> `hold_mask`=00000 and `roll_en` high for exactly 8 cycles; then `roll_count`=1 and `dice_valid`=1.
- Hold latch and roll limit:
  - Second roll with `hold_sw`=00011, toggling `hold_sw` during ROLLING -> `hold_mask` stays 00011.
  - After the third roll, `roll_btn` -> no `roll_en`, `roll_count` stays 3.
  - `hold_sw`=11111 and `roll_btn` after the first roll -> ignored.
- Score handshake: `roll_btn`+`score_btn` in the same cycle in DECIDE -> `score_req`=1, no `roll_en`. `score_ack` 5 cycles later -> `score_req` falls next cycle, `player`=1, `roll_count`=0.
- Game end: NUM_ROUNDS=2, play 4 turns -> `game_over`=1 after the 4th ack, `round_num`=2, then `start_btn` -> READY with `round_num`=1.
- Reset mid-operation: `reset` in the 4th cycle of ROLLING -> `roll_en`=0 on the next edge, state IDLE; `reset` during SCORE_WAIT -> `score_req`=0 on the next edge.
